// File: rtl/vmem_sequencer.sv
// Memory-stage sequencer: turns scalar/vector load-store requests into word beats on a
// ready/valid data-memory port, stalling the pipeline until the final beat completes.
module vmem_sequencer #(
  parameter int LANES  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      memwriteM,
  input  logic                      memtoregM,
  input  logic                      memdataM,
  input  logic [ADDR_W-1:0]         addrM,
  input  logic [DATA_W-1:0]         wdataM,
  input  logic [LANES*DATA_W-1:0]   vwdataM,
  output logic                      stallM,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [DATA_W-1:0]         rdataM,
  output logic [LANES*DATA_W-1:0]   vrdataM,
  output logic                      doneM
);

  localparam int LaneW = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    stateQ;
  state_t                    stateD;
  logic                      vecQ;
  logic [LANES*DATA_W-1:0]   vwdataQ;
  logic [LaneW-1:0]          laneQ;
  logic [LaneW-1:0]          laneNext;
  logic                      memReqQ;
  logic                      memWeQ;
  logic [ADDR_W-1:0]         memAddrQ;
  logic [DATA_W-1:0]         memWdataQ;
  logic                      req;
  logic                      accept;
  logic                      beatDone;
  logic                      lastBeat;

  assign req      = memwriteM | memtoregM;
  assign laneNext = laneQ + LaneW'(1);
  assign lastBeat = !vecQ || (laneQ == LaneW'(LANES - 1));
  assign beatDone = (stateQ == BUSY) && mem_ready;

  assign mem_req   = memReqQ;
  assign mem_we    = memWeQ;
  assign mem_addr  = memAddrQ;
  assign mem_wdata = memWdataQ;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state, stall and completion decode
  always_comb begin
    stateD = stateQ;
    stallM = 1'b0;
    doneM  = 1'b0;
    accept = 1'b0;
    case (stateQ)
      IDLE: begin
        if (req) begin
          // nothing stalls while reset is held, even with a request pending
          stallM = reset;
          accept = 1'b1;
          stateD = BUSY;
        end else begin
          stateD = IDLE;
        end
      end
      BUSY: begin
        stallM = 1'b1;
        if (mem_ready && lastBeat) begin
          stateD = DONE;
        end else begin
          stateD = BUSY;
        end
      end
      DONE: begin
        doneM  = 1'b1;
        stateD = IDLE;
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // Command latch, beat sequencing and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vecQ      <= 1'b0;
      vwdataQ   <= '0;
      laneQ     <= '0;
      memReqQ   <= 1'b0;
      memWeQ    <= 1'b0;
      memAddrQ  <= '0;
      memWdataQ <= '0;
      rdataM    <= '0;
      vrdataM   <= '0;
    end else if (accept) begin
      vecQ      <= memdataM;
      vwdataQ   <= vwdataM;
      laneQ     <= '0;
      memReqQ   <= 1'b1;
      memWeQ    <= memwriteM;
      memAddrQ  <= addrM;
      memWdataQ <= memdataM ? vwdataM[DATA_W-1:0] : wdataM;
    end else if (beatDone) begin
      if (!memWeQ) begin
        if (vecQ) begin
          vrdataM[int'(laneQ)*DATA_W +: DATA_W] <= mem_rdata;
        end else begin
          rdataM <= mem_rdata;
        end
      end
      if (lastBeat) begin
        memReqQ <= 1'b0;
        memWeQ  <= 1'b0;
      end else begin
        // address and lane data advance only on an accepted beat
        laneQ     <= laneNext;
        memAddrQ  <= memAddrQ + ADDR_W'(32'd4);
        memWdataQ <= vwdataQ[int'(laneNext)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_vmem_sequencer.sv
// Directed bench for vmem_sequencer: a per-request timeline model drives the memory side
// and a single negedge compare process checks every cycle against it.
module tb_vmem_sequencer;

  localparam int LANES = 8;
  localparam int DW    = 32;
  localparam int AW    = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  memwriteM, memtoregM, memdataM;
  logic [AW-1:0]         addrM;
  logic [DW-1:0]         wdataM;
  logic [LANES*DW-1:0]   vwdataM;
  logic                  stallM, mem_req, mem_we, mem_ready, doneM;
  logic [AW-1:0]         mem_addr;
  logic [DW-1:0]         mem_wdata, mem_rdata, rdataM;
  logic [LANES*DW-1:0]   vrdataM;

  vmem_sequencer #(.LANES(LANES), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .memwriteM(memwriteM), .memtoregM(memtoregM),
    .memdataM(memdataM), .addrM(addrM), .wdataM(wdataM), .vwdataM(vwdataM),
    .stallM(stallM), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rdataM(rdataM), .vrdataM(vrdataM), .doneM(doneM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rstIn, reqIn, scramble, rdy;
    logic [31:0]  rd;
    logic         stall, req, we, done, chkW, chkData, clrCnt;
    logic [31:0]  addr, wdata, expR;
    logic [255:0] expV;
    logic         pinAddrEn, pinWdEn, pinREn;
    logic [31:0]  pinAddr, pinWdata, pinR;
    int           pinStall;
  } step_t;

  step_t        cmpQ[$];
  int           errors = 0;
  int           checks = 0;
  int           stallCnt = 0;
  logic [31:0]  mR = 32'h0;
  logic [255:0] mV = '0;
  logic         cw, cr, cv;
  logic [31:0]  ca, cwd;
  logic [255:0] cvw;

  function automatic step_t blank();
    step_t s;
    s = '{default: '0};
    s.expR = mR;
    s.expV = mV;
    return s;
  endfunction

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single compare process: one expected step per cycle
  always @(negedge clk) begin : cmp
    step_t s;
    if (cmpQ.size() > 0) begin
      s = cmpQ.pop_front();
      if (s.clrCnt) stallCnt = 0;
      else if (stallM === 1'b1) stallCnt++;
      check("stallM", stallM, s.stall);
      check("mem_req", mem_req, s.req);
      check("doneM", doneM, s.done);
      check("mem_we", mem_we, s.req ? s.we : 1'b0);
      check("mem_known", $isunknown(mem_addr) || $isunknown(mem_wdata), 1'b0);
      if (s.req) check("mem_addr", mem_addr, s.addr);
      if (s.chkW) check("mem_wdata", mem_wdata, s.wdata);
      if (s.chkData) begin
        check("rdataM", rdataM, s.expR);
        check("vrdataM", vrdataM, s.expV);
      end
      if (s.pinAddrEn) check("pin_addr", mem_addr, s.pinAddr);
      if (s.pinWdEn) check("pin_wdata", mem_wdata, s.pinWdata);
      if (s.pinREn) check("pin_rdata", rdataM, s.pinR);
      if (s.pinStall > 0) begin
        check("stall_cycles", stallCnt, s.pinStall);
        stallCnt = 0;
      end
    end
  end

  task automatic drive(input step_t s);
    @(posedge clk);
    #1;
    reset     = !s.rstIn;
    memwriteM = s.reqIn & cw;
    memtoregM = s.reqIn & cr;
    if (s.scramble) begin
      addrM    = $urandom;
      wdataM   = $urandom;
      memdataM = 1'($urandom_range(0, 1));
      for (int k = 0; k < LANES; k++) vwdataM[k*32 +: 32] = $urandom;
    end else begin
      addrM    = ca;
      wdataM   = cwd;
      memdataM = cv;
      vwdataM  = cvw;
    end
    mem_ready = s.rdy;
    mem_rdata = s.rd;
    cmpQ.push_back(s);
  endtask

  // Expected cycle timeline of one request: request cycle, beats (with ready-low waits), DONE, idle
  task automatic runReq(input logic w, input logic r, input logic v, input logic [31:0] a,
                        input logic [31:0] wd, input logic [255:0] vw, input logic [31:0] rdBase,
                        input int waitA, input int waitB, input int waitLen, input int stopAfter,
                        input int pinStall, input logic [31:0] pinLastAddr,
                        input logic pinWdEn, input logic [31:0] pinLastWd,
                        input logic pinREn, input logic [31:0] pinR);
    step_t       s;
    int          n;
    int          nw;
    logic [31:0] rv;
    cw = w; cr = r; cv = v; ca = a; cwd = wd; cvw = vw;
    n = v ? LANES : 1;
    s = blank();
    s.reqIn = 1'b1; s.stall = 1'b1; s.chkData = 1'b1; s.rdy = 1'b1; s.rd = 32'h5A5A_5A5A;
    drive(s);
    for (int i = 0; i < n; i++) begin
      if (i == stopAfter) return;
      nw = (i == waitA || i == waitB) ? waitLen : 0;
      rv = v ? rdBase + 32'(i) : rdBase;
      for (int j = 0; j <= nw; j++) begin
        s = blank();
        s.reqIn = 1'b1; s.scramble = 1'b1; s.stall = 1'b1; s.req = 1'b1; s.we = w;
        s.addr  = a + 32'(4 * i);
        s.wdata = v ? vw[i*32 +: 32] : wd;
        s.chkW  = w;
        s.rdy   = (j == nw);
        s.rd    = (j == nw) ? rv : (32'hBAD0_0000 | 32'(j));
        if (j == nw && i == n - 1) begin
          s.pinAddrEn = 1'b1; s.pinAddr = pinLastAddr;
          s.pinWdEn = pinWdEn; s.pinWdata = pinLastWd;
        end
        drive(s);
      end
      if (!w) begin
        if (v) mV[i*32 +: 32] = rv;
        else   mR = rv;
      end
    end
    s = blank();
    s.reqIn = 1'b1; s.done = 1'b1; s.chkData = 1'b1; s.rdy = 1'b1;
    s.pinStall = pinStall; s.pinREn = pinREn; s.pinR = pinR;
    drive(s);
    s = blank();
    s.chkData = 1'b1; s.rdy = 1'b1;
    drive(s);
  endtask

  initial begin
    step_t        s;
    logic [255:0] vs;
    reset = 1'b0; memwriteM = 1'b0; memtoregM = 1'b0; memdataM = 1'b0;
    addrM = '0; wdataM = '0; vwdataM = '0; mem_ready = 1'b0; mem_rdata = '0;
    cw = 1'b0; cr = 1'b0; cv = 1'b0; ca = '0; cwd = '0; cvw = '0;

    // reset values
    s = blank();
    s.rstIn = 1'b1; s.clrCnt = 1'b1; s.chkData = 1'b1;
    s.pinAddrEn = 1'b1; s.pinAddr = 32'h0; s.pinWdEn = 1'b1; s.pinWdata = 32'h0;
    drive(s);
    for (int k = 0; k < 3; k++) begin
      s = blank(); s.chkData = 1'b1; s.rdy = 1'b1;
      drive(s);
    end

    // scalar load
    runReq(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, '0, 32'hDEAD_BEEF, -1, -1, 0, 99,
           2, 32'h100, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // vector store, lane i = i+1
    for (int i = 0; i < LANES; i++) vs[i*32 +: 32] = 32'(i + 1);
    runReq(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, vs, 32'hEEEE_0000, -1, -1, 0, 99,
           9, 32'h21C, 1'b1, 32'h8, 1'b1, 32'hDEAD_BEEF);

    // vector load with ready low on beats 0 and 5 for two cycles each
    runReq(1'b0, 1'b1, 1'b1, 32'h300, 32'h0, '0, 32'hC0DE_0010, 0, 5, 2, 99,
           13, 32'h31C, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // address wrap
    runReq(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0, '0, 32'h7777_0000, -1, -1, 0, 99,
           9, 32'h14, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);

    // both request bits: one write beat, rdataM untouched
    runReq(1'b1, 1'b1, 1'b0, 32'h40, 32'hCAFE_F00D, '0, 32'h1111_2222, -1, -1, 0, 99,
           2, 32'h40, 1'b1, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF);

    // reset after beat 3 of a vector load, request still asserted
    runReq(1'b0, 1'b1, 1'b1, 32'h500, 32'h0, '0, 32'h1234_0000, -1, -1, 0, 4,
           0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    mR = 32'h0;
    mV = '0;
    s = blank();
    s.rstIn = 1'b1; s.reqIn = 1'b1; s.clrCnt = 1'b1; s.chkData = 1'b1;
    drive(s);
    s = blank(); s.rstIn = 1'b1; s.chkData = 1'b1;
    drive(s);
    s = blank(); s.chkData = 1'b1;
    drive(s);

    // normal scalar load after reset
    runReq(1'b0, 1'b1, 1'b0, 32'h600, 32'h0, '0, 32'h0BAD_CAFE, -1, -1, 0, 99,
           2, 32'h600, 1'b0, 32'h0, 1'b1, 32'h0BAD_CAFE);

    @(negedge clk);
    #1;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vmem_sequencer.md
# vmem_sequencer

Memory-stage responder for the load/store control issued by the pipeline controller. It accepts scalar and vector memory requests from the M stage, signalled by `memwriteM`, `memtoregM` and `memdataM`. Each request becomes one or more word transactions on a ready/valid data-memory port, and `stallM` freezes the pipeline until the last beat completes. Read data is collected into a scalar word and a LANES-wide vector register, which feed writeback.

## Interface
Parameters:
- `LANES`, default 8: words per vector transfer; power of two, ≥2.
- `DATA_W`, default 32: word width.
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `memwriteM`, in, 1: M-stage store request.
- `memtoregM`, in, 1: M-stage load request.
- `memdataM`, in, 1: 1 = vector transfer of LANES words; 0 = scalar single word.
- `addrM`, in, ADDR_W: base byte address.
- `wdataM`, in, DATA_W: scalar store data.
- `vwdataM`, in, LANES*DATA_W: vector store data; lane i is bits [i*DATA_W +: DATA_W].
- `stallM`, out, 1: freeze F/D/E/M pipeline registers.
- `mem_req`, out, 1: memory transaction valid.
- `mem_we`, out, 1: transaction is a write.
- `mem_addr`, out, ADDR_W: transaction byte address.
- `mem_wdata`, out, DATA_W: transaction write data.
- `mem_ready`, in, 1: memory accepts/completes the current beat.
- `mem_rdata`, in, DATA_W: read data, valid when `mem_req && mem_ready && !mem_we`.
- `rdataM`, out, DATA_W: last scalar load result.
- `vrdataM`, out, LANES*DATA_W: last vector load result.
- `doneM`, out, 1: one-cycle pulse when a request completes.

## Operation
- The FSM has three states: IDLE, BUSY and DONE. Reset enters IDLE.
- A request is `req = memwriteM | memtoregM`. If both bits are high, the transfer is a write.
- **IDLE:**
  - If `req`, latch the command: `we`, `vec = memdataM`, the base address, `wdataM` and `vwdataM`.
  - Clear the lane counter to 0 and go to BUSY.
  - `stallM` is combinationally high in this cycle, so the instruction stays in M.
- **BUSY:**
  - `mem_req` is 1.
  - `mem_addr = base + 4*lane`, truncated to ADDR_W, so it wraps modulo 2^ADDR_W. There is no alignment check.
  - `mem_wdata` is the latched scalar word, or vector lane `lane` when `vec` is set.
- **Beat completion:** a beat completes on a cycle with `mem_ready` high.
  - On a load, capture `mem_rdata` into `vrdataM` lane `lane`. Scalar loads write `rdataM`, and `vrdataM` is untouched.
  - On a store, nothing is captured.
  - If this is the last beat (scalar, or `lane == LANES-1`), go to DONE. Otherwise increment `lane`.
- **DONE:**
  - `stallM` is 0 and `doneM` is 1.
  - Inputs are ignored, because the completed instruction is still in M this cycle.
  - Go to IDLE unconditionally.
- `stallM = (IDLE && req) || BUSY`.
- `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` are driven from registered state only.
- Outside BUSY, `mem_req = 0` and `mem_we = 0`. `mem_addr` and `mem_wdata` are don't-care but must not be X.
- Unstalled cycles with `req = 0` leave all state unchanged.

## Timing
- **Reset values:** IDLE, lane 0, `stallM = 0`, `mem_req = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`, `rdataM = 0`, `vrdataM = 0`, `doneM = 0`.
- **Reset mid-operation:** it takes effect immediately (asynchronous). The transfer is abandoned, partially filled lanes are cleared to 0, and there is no DONE pulse.
- **Latency with `mem_ready` tied high:**
  - Scalar: request cycle + 1 BUSY cycle = 2 stall cycles; DONE in cycle 2.
  - Vector: 1 + LANES stall cycles; DONE in cycle LANES+1.
- **Each `mem_ready = 0` cycle in BUSY** holds `lane`, address and data stable and adds exactly one stall cycle.
- **Outputs after completion:** `rdataM` and `vrdataM` become valid in the DONE cycle and hold until the next load completes.
- **Back-to-back requests:** a new request is accepted no earlier than the cycle after DONE, so the minimum gap is one unstalled cycle.
- **`mem_ready` outside BUSY** is ignored.

## Test plan
- **Scalar load:** `reset` released, `memtoregM = 1`, `memdataM = 0`, `addrM = 0x100`, memory returns `0xDEADBEEF` with ready always high.
  - `stallM` is high for exactly 2 cycles, with `mem_addr = 0x100` and `mem_we = 0`.
  - `doneM` pulses once and `rdataM = 0xDEADBEEF`.
- **Vector store:** `memwriteM = 1`, `memdataM = 1`, `addrM = 0x200`, lane i = i+1.
  - 8 beats at 0x200, 0x204 … 0x21C with `mem_wdata` 1…8 and `mem_we = 1`.
  - `stallM` is high for 9 cycles.
- **Vector load with backpressure:** `mem_ready` low on beats 0 and 5 for 2 cycles each.
  - Address and lane are held during the low cycles.
  - `stallM` is high for 13 cycles and `vrdataM` lanes equal the returned words in order.
- **Address wrap:** vector load at `addrM = 0xFFFFFFF8`.
  - Beat addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x0, … 0x14.
- **Both request bits high:** `memwriteM = memtoregM = 1`, scalar.
  - A single write beat is issued and `rdataM` is unchanged.
- **Reset mid-vector-load:** `reset` asserted low after beat 3.
  - `mem_req`, `stallM` and `doneM` drop to 0 at once and `vrdataM = 0`.
  - A new scalar request after release completes normally in 2 stall cycles.
